fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter NB_CYCLE_CNT, default 32, width of the advance-cycle counter.
REQ-002 Parameter N_DRAIN, default 4, number of pipeline-drain cycles after a HALT instruction; legal range 1..15.
REQ-003 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_start  in  1  debug command: begin continuous execution.
REQ-006 i_step  in  1  debug command: advance pipeline exactly one cycle.
REQ-007 i_stop  in  1  debug command: stop continuous execution.
REQ-008 i_stall  in  1  load-use hazard from decode; freezes PC for the current cycle.
REQ-009 i_halt_instr  in  1  HALT opcode decoded in ID this cycle.
REQ-010 i_branch_taken, i_jump_rs, i_jump_inm  in  1 each  redirect requests from decode.
REQ-011 o_fetch_valid  out  1  PC/IR update enable to the fetch stage.
REQ-012 o_pipe_enable  out  1  advance enable for all stages after fetch.
REQ-013 o_branch, o_jump_rs, o_jump_inm  out  1 each  one-hot PC-select to the fetch stage.
REQ-014 o_nop_reg  out  1  replaces the fetched instruction with NOP (all-zero) when high.
REQ-015 o_state  out  3  current state: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALT=4.
REQ-016 o_halted  out  1  high only in HALT.
REQ-017 o_cycle_count  out  NB_CYCLE_CNT  number of cycles with o_pipe_enable high.

Function
REQ-018 Advance cycle ("adv") SHALL be state RUN or STEP; o_pipe_enable SHALL be 1 in RUN, STEP, DRAIN and 0 in IDLE, HALT.
REQ-019 o_fetch_valid SHALL equal adv & ~i_stall & ~i_halt_instr (combinational).
REQ-020 Redirect SHALL be accepted only when o_fetch_valid=1; priority branch > jump_rs > jump_inm; the three selects SHALL be one-hot or all zero, never multiple.
REQ-021 Internal nop flag SHALL load "redirect accepted" on every adv cycle, hold otherwise; o_nop_reg = nop flag | (state==DRAIN).
REQ-022 IDLE: i_start -> RUN; else i_step -> STEP; start wins if both; i_stop ignored.
REQ-023 RUN: i_halt_instr & ~i_stall -> DRAIN; else i_stop -> IDLE; halt wins over stop; i_start, i_step ignored.
REQ-024 STEP: lasts exactly one cycle; i_halt_instr & ~i_stall -> DRAIN, else -> IDLE; i_stop, i_start, i_step ignored.
REQ-025 DRAIN: 4-bit down-counter loaded with N_DRAIN-1 on entry, decrements each cycle; at 0 -> HALT; DRAIN SHALL last exactly N_DRAIN cycles; all commands ignored.
REQ-026 HALT: terminal; only i_reset exits; all commands ignored.
REQ-027 i_halt_instr while i_stall=1 SHALL be ignored that cycle (re-presented by decode after the stall).
REQ-028 HALT instruction and redirect in the same adv cycle: halt wins, selects all zero, o_fetch_valid=0.
REQ-029 o_cycle_count SHALL increment by 1 on each cycle with o_pipe_enable=1, saturate at all-ones, never wrap.
REQ-030 All outputs other than o_fetch_valid and redirect selects SHALL be registered or derived only from registered state.

Reset
REQ-031 On i_reset=1 at a clock edge: state IDLE, nop flag 0, drain counter 0, o_cycle_count 0; reset SHALL take priority over all inputs, including mid-DRAIN or HALT.
REQ-032 While in reset-induced IDLE all outputs SHALL be 0 (o_state=0, o_halted=0).

Verification
REQ-033 Reset, then i_start pulse, 10 idle cycles -> o_state=1, o_fetch_valid=1 each cycle, o_cycle_count=10, o_nop_reg=0.
REQ-034 IDLE, i_step pulse -> one cycle o_state=2, o_pipe_enable=1, then o_state=0; o_cycle_count increments by exactly 1.
REQ-035 RUN, i_branch_taken=i_jump_rs=1 same cycle -> o_branch=1, o_jump_rs=0; next cycle o_nop_reg=1; with no redirect the cycle after, o_nop_reg=0.
REQ-036 RUN, i_stall=1 with i_jump_inm=1 -> o_fetch_valid=0, all selects 0, o_pipe_enable=1.
REQ-037 RUN, i_halt_instr=1 and i_stop=1 (N_DRAIN=4) -> 4 cycles o_state=3, o_nop_reg=1, o_fetch_valid=0; then o_state=4, o_halted=1, o_pipe_enable=0; i_start ignored.
REQ-038 i_reset during DRAIN cycle 2 -> next edge o_state=0, o_cycle_count=0, o_nop_reg=0; preset counter to all-ones-1, run 3 cycles -> count stays all-ones.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Debug-controlled fetch/pipeline sequencer: run/step/stop commands, HALT drain,
// one-hot redirect select and a saturating advance-cycle counter.
//
// state | meaning
// IDLE  | pipeline frozen, waiting for start or step
// RUN   | continuous execution, pipeline advances every cycle
// STEP  | single advance cycle, then back to IDLE
// DRAIN | HALT seen, NOPs fed for N_DRAIN cycles to flush the pipeline
// HALT  | terminal, frozen until reset
module fetch_sequencer #(
    parameter int NB_CYCLE_CNT = 32,
    parameter int N_DRAIN      = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_step,
    input  logic                    i_stop,
    input  logic                    i_stall,
    input  logic                    i_halt_instr,
    input  logic                    i_branch_taken,
    input  logic                    i_jump_rs,
    input  logic                    i_jump_inm,
    output logic                    o_fetch_valid,
    output logic                    o_pipe_enable,
    output logic                    o_branch,
    output logic                    o_jump_rs,
    output logic                    o_jump_inm,
    output logic                    o_nop_reg,
    output logic [2:0]              o_state,
    output logic                    o_halted,
    output logic [NB_CYCLE_CNT-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(N_DRAIN - 1);
    localparam logic [NB_CYCLE_CNT-1:0] CNT_ONE = {{(NB_CYCLE_CNT-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [3:0]              drain_q, drain_d;
    logic                    nop_q, nop_d;
    logic [NB_CYCLE_CNT-1:0] count_q, count_d;

    logic adv;
    logic halt_accept;
    logic redirect;

    assign adv         = (state_q == RUN) || (state_q == STEP);
    assign halt_accept = i_halt_instr && !i_stall;

    // Halt in ID suppresses fetch, so a simultaneous redirect is dropped too.
    assign o_fetch_valid = adv && !i_stall && !i_halt_instr;
    assign o_branch      = o_fetch_valid && i_branch_taken;
    assign o_jump_rs     = o_fetch_valid && !i_branch_taken && i_jump_rs;
    assign o_jump_inm    = o_fetch_valid && !i_branch_taken && !i_jump_rs && i_jump_inm;
    assign redirect      = o_branch || o_jump_rs || o_jump_inm;

    assign o_pipe_enable = adv || (state_q == DRAIN);
    assign o_nop_reg     = nop_q || (state_q == DRAIN);
    assign o_state       = state_q;
    assign o_halted      = (state_q == HALT);
    assign o_cycle_count = count_q;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                end else if (i_step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (halt_accept) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (i_stop) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                if (halt_accept) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (drain_q == 4'd0) begin
                    state_d = HALT;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nop_d   = adv ? redirect : nop_q;
        count_d = count_q;
        if (o_pipe_enable && (count_q != {NB_CYCLE_CNT{1'b1}})) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            drain_q <= 4'd0;
            nop_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            nop_q   <= nop_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a default instance for sequencing and a
// 3-bit-counter instance for saturation.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, step, stop, stall, halt, br, jrs, jinm;
    logic        fv, pe, o_br, o_jrs, o_jinm, nop, halted;
    logic [2:0]  st;
    logic [31:0] cnt;

    logic        s_rst, s_start, s_step, s_zero;
    logic        s_fv, s_pe, s_br, s_jrs, s_jinm, s_nop, s_halted;
    logic [2:0]  s_st;
    logic [2:0]  s_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_cnt  = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_step(step), .i_stop(stop),
        .i_stall(stall), .i_halt_instr(halt), .i_branch_taken(br), .i_jump_rs(jrs),
        .i_jump_inm(jinm), .o_fetch_valid(fv), .o_pipe_enable(pe), .o_branch(o_br),
        .o_jump_rs(o_jrs), .o_jump_inm(o_jinm), .o_nop_reg(nop), .o_state(st),
        .o_halted(halted), .o_cycle_count(cnt)
    );

    fetch_sequencer #(.NB_CYCLE_CNT(3), .N_DRAIN(2)) dut_sat (
        .i_clock(clk), .i_reset(s_rst), .i_start(s_start), .i_step(s_step), .i_stop(s_zero),
        .i_stall(s_zero), .i_halt_instr(s_zero), .i_branch_taken(s_zero), .i_jump_rs(s_zero),
        .i_jump_inm(s_zero), .o_fetch_valid(s_fv), .o_pipe_enable(s_pe), .o_branch(s_br),
        .o_jump_rs(s_jrs), .o_jump_inm(s_jinm), .o_nop_reg(s_nop), .o_state(s_st),
        .o_halted(s_halted), .o_cycle_count(s_cnt)
    );

    task automatic clear_inputs();
        start = 0; step = 0; stop = 0; stall = 0; halt = 0; br = 0; jrs = 0; jinm = 0;
    endtask

    // Edge with the pipeline expected enabled (counter advances) or frozen.
    task automatic adv_cyc();
        @(posedge clk); #1;
        exp_cnt++;
    endtask

    task automatic idle_cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        idle_cyc();
        idle_cyc();
        rst = 0; exp_cnt = 0;
        #1;
        n_checks++;
        if ({st, halted, pe, fv, nop, o_br, o_jrs, o_jinm} !== 10'b0 || cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%0d halted=%b pe=%b fv=%b nop=%b sel=%b%b%b cnt=%0d, required all zero",
                     st, halted, pe, fv, nop, o_br, o_jrs, o_jinm, cnt);
        end
        stop = 1; idle_cyc(); stop = 0;
        n_checks++;
        if (st !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_stop_ignored: state=%0d required 0", st);
        end
    endtask

    task automatic test_run();
        start = 1; idle_cyc(); start = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (st !== 3'd1 || fv !== 1'b1 || nop !== 1'b0 || pe !== 1'b1) begin
                n_fail++;
                $display("FAIL run_cycle%0d: state=%0d fv=%b nop=%b pe=%b required 1/1/0/1", i, st, fv, nop, pe);
            end
            adv_cyc();
        end
        n_checks++;
        if (cnt !== 32'd10) begin
            n_fail++;
            $display("FAIL run_count: cnt=%0d required 10", cnt);
        end
        step = 1; adv_cyc(); step = 0;
        n_checks++;
        if (st !== 3'd1) begin
            n_fail++;
            $display("FAIL run_step_ignored: state=%0d required 1", st);
        end
        stop = 1; adv_cyc(); stop = 0;
        n_checks++;
        if (st !== 3'd0 || cnt !== 32'd12) begin
            n_fail++;
            $display("FAIL run_stop: state=%0d cnt=%0d required 0/12", st, cnt);
        end
    endtask

    task automatic test_step();
        step = 1; adv_cyc(); step = 0;
        n_checks++;
        if (st !== 3'd2 || pe !== 1'b1 || fv !== 1'b1 || cnt !== 32'd12) begin
            n_fail++;
            $display("FAIL step_state: state=%0d pe=%b fv=%b cnt=%0d required 2/1/1/12", st, pe, fv, cnt);
        end
        start = 1; idle_cyc(); start = 0;
        n_checks++;
        if (st !== 3'd0 || pe !== 1'b0 || cnt !== 32'd13) begin
            n_fail++;
            $display("FAIL step_return: state=%0d pe=%b cnt=%0d required 0/0/13", st, pe, cnt);
        end
    endtask

    task automatic test_redirect();
        start = 1; step = 1; idle_cyc(); start = 0; step = 0;
        n_checks++;
        if (st !== 3'd1) begin
            n_fail++;
            $display("FAIL start_beats_step: state=%0d required 1", st);
        end
        br = 1; jrs = 1; #1;
        n_checks++;
        if ({o_br, o_jrs, o_jinm} !== 3'b100 || fv !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_branch_prio: sel=%b%b%b fv=%b required 100/1", o_br, o_jrs, o_jinm, fv);
        end
        adv_cyc(); br = 0; jrs = 0; #1;
        n_checks++;
        if (nop !== 1'b1) begin
            n_fail++;
            $display("FAIL nop_after_branch: nop=%b required 1", nop);
        end
        adv_cyc();
        n_checks++;
        if (nop !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_clears: nop=%b required 0", nop);
        end
        jrs = 1; jinm = 1; #1;
        n_checks++;
        if ({o_br, o_jrs, o_jinm} !== 3'b010) begin
            n_fail++;
            $display("FAIL sel_jrs_prio: sel=%b%b%b required 010", o_br, o_jrs, o_jinm);
        end
        jrs = 0; #1;
        n_checks++;
        if ({o_br, o_jrs, o_jinm} !== 3'b001) begin
            n_fail++;
            $display("FAIL sel_jinm: sel=%b%b%b required 001", o_br, o_jrs, o_jinm);
        end
        adv_cyc(); jinm = 0;
        adv_cyc();
    endtask

    task automatic test_stall();
        stall = 1; jinm = 1; #1;
        n_checks++;
        if (fv !== 1'b0 || {o_br, o_jrs, o_jinm} !== 3'b000 || pe !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_redirect: fv=%b sel=%b%b%b pe=%b required 0/000/1", fv, o_br, o_jrs, o_jinm, pe);
        end
        jinm = 0; halt = 1;
        adv_cyc();
        n_checks++;
        if (st !== 3'd1 || nop !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_halt_ignored: state=%0d nop=%b required 1/0", st, nop);
        end
        stall = 0; halt = 0;
    endtask

    task automatic test_halt_drain();
        halt = 1; br = 1; stop = 1; #1;
        n_checks++;
        if (fv !== 1'b0 || {o_br, o_jrs, o_jinm} !== 3'b000) begin
            n_fail++;
            $display("FAIL halt_beats_redirect: fv=%b sel=%b%b%b required 0/000", fv, o_br, o_jrs, o_jinm);
        end
        adv_cyc(); halt = 0; br = 0; stop = 0; start = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (st !== 3'd3 || nop !== 1'b1 || fv !== 1'b0 || pe !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_cycle%0d: state=%0d nop=%b fv=%b pe=%b required 3/1/0/1", i, st, nop, fv, pe);
            end
            adv_cyc();
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (st !== 3'd4 || halted !== 1'b1 || pe !== 1'b0 || cnt !== 32'(exp_cnt)) begin
                n_fail++;
                $display("FAIL halt_cycle%0d: state=%0d halted=%b pe=%b cnt=%0d required 4/1/0/%0d",
                         i, st, halted, pe, cnt, exp_cnt);
            end
            step = 1; idle_cyc();
        end
        clear_inputs();
    endtask

    task automatic test_reset_drain();
        rst = 1; idle_cyc(); rst = 0;
        n_checks++;
        if (st !== 3'd0 || halted !== 1'b0 || cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_from_halt: state=%0d halted=%b cnt=%0d required 0/0/0", st, halted, cnt);
        end
        start = 1; idle_cyc(); start = 0;
        br = 1; adv_cyc(); br = 0;
        halt = 1; adv_cyc(); halt = 0;
        adv_cyc();
        n_checks++;
        if (st !== 3'd3) begin
            n_fail++;
            $display("FAIL reach_drain2: state=%0d required 3", st);
        end
        rst = 1; start = 1; idle_cyc(); rst = 0; start = 0;
        n_checks++;
        if (st !== 3'd0 || cnt !== 32'd0 || nop !== 1'b0 || pe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: state=%0d cnt=%0d nop=%b pe=%b required 0/0/0/0", st, cnt, nop, pe);
        end
    endtask

    task automatic test_saturate();
        s_rst = 1; idle_cyc(); s_rst = 0;
        s_start = 1; idle_cyc(); s_start = 0;
        for (int i = 0; i < 6; i++) idle_cyc();
        n_checks++;
        if (s_cnt !== 3'd6 || s_st !== 3'd1) begin
            n_fail++;
            $display("FAIL sat_preset: cnt=%0d state=%0d required 6/1", s_cnt, s_st);
        end
        for (int i = 0; i < 3; i++) begin
            idle_cyc();
            n_checks++;
            if (s_cnt !== 3'd7) begin
                n_fail++;
                $display("FAIL sat_hold%0d: cnt=%0d required 7", i, s_cnt);
            end
        end
    endtask

    initial begin
        s_rst = 1; s_start = 0; s_step = 0; s_zero = 0;
        test_reset();
        test_run();
        test_step();
        exp_cnt = 13;
        test_redirect();
        test_stall();
        test_halt_drain();
        test_reset_drain();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
